// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: in-place radix-2 DIF FFT read/write-back address sequencer with inter-stage drain.
module fft_stage_sequencer #(
  parameter int LOG2N = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);
  localparam int KW = LOG2N - 1;
  localparam int DW = 2 * LOG2N + 1;
  localparam int DLW = PIPE_LAT * DW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic [3:0] s, s_n, d, d_n;
  logic [DLW-1:0] dl;
  logic [LOG2N-1:0] kk, span, lo, addr_a;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      s <= '0;
      d <= '0;
      dl <= '0;
    end else if (en) begin
      state <= state_n;
      k <= k_n;
      s <= s_n;
      d <= d_n;
      dl <= DLW'({dl, rd_en, rd_addr_a, rd_addr_b});
    end
  end
  always_comb begin
    state_n = state;
    k_n = k;
    s_n = s;
    d_n = d;
    unique case (state)
      IDLE: if (start) begin
        state_n = RUN;
        k_n = '0;
        s_n = '0;
      end
      RUN: if (k == KW'((1 << KW) - 1)) begin
        state_n = DRAIN;
        d_n = '0;
      end else k_n = k + 1'b1;
      DRAIN: if (d == 4'(PIPE_LAT - 1)) begin
        state_n = (s == 4'(LOG2N - 1)) ? FINISH : RUN;
        s_n = (s == 4'(LOG2N - 1)) ? s : s + 4'd1;
        k_n = '0;
      end else d_n = d + 4'd1;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Upper-wing address is k with a zero bit inserted at the span position.
  always_comb begin
    kk = LOG2N'(k);
    span = LOG2N'(1) << (4'(KW) - s);
    lo = kk & (span - 1'b1);
    addr_a = ((kk & ~lo) << 1) | lo;
    rd_en = state == RUN;
    rd_addr_a = rd_en ? addr_a : '0;
    rd_addr_b = rd_en ? (addr_a | span) : '0;
    tw_idx = rd_en ? KW'(lo << s) : '0;
    {wr_en, wr_addr_a, wr_addr_b} = dl[DLW-1 -: DW];
    stage = s;
    busy = state == RUN || state == DRAIN;
    done = state == FINISH;
  end
endmodule
